// File: rtl/ifetch_if.sv
// ifetch_if -- bundles the fetch stage's memory bus and decode-side signals.
// master: the fetch unit (drives o_*); slave: the surrounding pipeline/memory.
interface ifetch_if;
   logic        i_stall;
   logic        i_redirect;
   logic [31:0] i_target;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_data;
   logic [31:0] o_ins;
   logic [31:0] o_pc;
   logic        o_valid;
   logic        o_misalign;

   modport master (
      input  i_stall, i_redirect, i_target, i_imem_ack, i_imem_data,
      output o_imem_req, o_imem_addr, o_ins, o_pc, o_valid, o_misalign
   );

   modport slave (
      output i_stall, i_redirect, i_target, i_imem_ack, i_imem_data,
      input  o_imem_req, o_imem_addr, o_ins, o_pc, o_valid, o_misalign
   );
endinterface

// File: rtl/ifetch.sv
// ifetch -- instruction fetch stage with a single outstanding memory request,
// a one-entry skid buffer for stalls, and redirect/flush handling.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to flag misaligned redirect
// targets (sticky o_misalign) and park the fetcher in HALT until an aligned
// redirect arrives. Without it, target bits [1:0] are ignored.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic      clk,
   input logic      rst,
   ifetch_if.master bus
);

   localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      S_REQ,
      S_HOLD,
      S_DRAIN
`ifdef IFETCH_ALIGN_CHECK_EN
      , S_HALT
`endif
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic [31:0] ins_q, ins_d;
   logic [31:0] opc_q, opc_d;
   logic        valid_q, valid_d;
   logic [31:0] buf_ins_q, buf_ins_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic        ack;
`ifdef IFETCH_ALIGN_CHECK_EN
   logic        mis_q, mis_d;
   logic        bad_target;
`endif

   // Memory response only counts while a request is actually being driven.
   assign ack = bus.i_imem_ack & bus.o_imem_req;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign bad_target = |bus.i_target[1:0];
`endif

   // State register: synchronous reset of every flop, buffer included.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC_W;
         drain_addr_q <= '0;
         ins_q        <= '0;
         opc_q        <= '0;
         valid_q      <= 1'b0;
         buf_ins_q    <= '0;
         buf_pc_q     <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
         mis_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         ins_q        <= ins_d;
         opc_q        <= opc_d;
         valid_q      <= valid_d;
         buf_ins_q    <= buf_ins_d;
         buf_pc_q     <= buf_pc_d;
`ifdef IFETCH_ALIGN_CHECK_EN
         mis_q        <= mis_d;
`endif
      end
   end

   // Next-state and datapath: redirect wins over stall and ack.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      ins_d        = ins_q;
      opc_d        = opc_q;
      valid_d      = valid_q;
      buf_ins_d    = buf_ins_q;
      buf_pc_d     = buf_pc_q;
`ifdef IFETCH_ALIGN_CHECK_EN
      mis_d        = mis_q;
`endif

      if (bus.i_redirect) begin
         // Flush: output bubble, buffer dropped, o_pc left as it was.
         pc_d      = {bus.i_target[31:2], 2'b00};
         valid_d   = 1'b0;
         ins_d     = '0;
         buf_ins_d = '0;
         buf_pc_d  = '0;
`ifdef IFETCH_ALIGN_CHECK_EN
         mis_d     = bad_target;
`endif
         case (state_q)
            S_REQ: begin
               if (!ack) begin
                  // Request still in flight on the old address: wait it out.
                  state_d      = S_DRAIN;
                  drain_addr_d = pc_q;
               end
            end
            // An ack landing in DRAIN completes the drain right now.
            S_DRAIN: state_d = ack ? S_REQ : S_DRAIN;
            default: state_d = S_REQ;
         endcase
`ifdef IFETCH_ALIGN_CHECK_EN
         // Misaligned target parks the fetcher once nothing is outstanding.
         if (bad_target && state_d == S_REQ) state_d = S_HALT;
`endif
      end else begin
         case (state_q)
            S_REQ: begin
               if (ack && !bus.i_stall) begin
                  ins_d   = bus.i_imem_data;
                  opc_d   = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + 32'd4;
               end else if (ack) begin
                  buf_ins_d = bus.i_imem_data;
                  buf_pc_d  = pc_q;
                  pc_d      = pc_q + 32'd4;
                  state_d   = S_HOLD;
               end else if (!bus.i_stall) begin
                  valid_d = 1'b0;
               end
            end
            S_HOLD: begin
               if (!bus.i_stall) begin
                  ins_d   = buf_ins_q;
                  opc_d   = buf_pc_q;
                  valid_d = 1'b1;
                  state_d = S_REQ;
               end
            end
            S_DRAIN: begin
               if (ack) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                  state_d = mis_q ? S_HALT : S_REQ;
`else
                  state_d = S_REQ;
`endif
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Memory-side outputs: request only in REQ/DRAIN and never during reset.
   always_comb begin
      bus.o_imem_req  = !rst && (state_q == S_REQ || state_q == S_DRAIN);
      bus.o_imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
   end

   assign bus.o_ins   = ins_q;
   assign bus.o_pc    = opc_q;
   assign bus.o_valid = valid_q;
`ifdef IFETCH_ALIGN_CHECK_EN
   assign bus.o_misalign = mis_q;
`else
   assign bus.o_misalign = 1'b0;
`endif

endmodule
